// File: rtl/disp_sr_rx.sv
// disp_sr_rx: receiver and monitor for a daisy-chained TLC59282 LED driver chain.
// It samples the serial bus in the clk domain, mirrors the chain shift register,
// latches it on lat, judges each frame by its bit count and measures the unblanked time.
//
// Handshake note: this block has no valid/ready pair. frm_valid and frm_err are
// single-cycle registered pulses with no backpressure, and they are never high together.
module disp_sr_rx #(
   parameter int N_DRV   = 4,
   parameter int SR_BITS = 16 * N_DRV
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               disp_sclk,
   input  logic               disp_sin,
   input  logic               disp_lat,
   input  logic               disp_blank,
   input  logic               meas_stb,
   output logic [SR_BITS-1:0] led_data,
   output logic [SR_BITS-1:0] led_out,
   output logic               frm_valid,
   output logic               frm_err,
   output logic [15:0]        frm_cnt,
   output logic [15:0]        err_cnt,
   output logic [31:0]        on_cnt,
   output logic [1:0]         dbg_state
);

   // The count runs 0..SR_BITS+1. The extra value marks an overlong frame.
   localparam int CW = $clog2(SR_BITS + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(SR_BITS);
   localparam logic [CW-1:0] CNT_OVER = CW'(SR_BITS + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_OVER  = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_adv;

   logic sclk_q, sclk_d, sclk_dly_q, sclk_dly_d;
   logic lat_q, lat_d, lat_dly_q, lat_dly_d;
   logic sin_q, sin_d, blank_q, blank_d;
   logic sclk_rise, lat_rise, frame_ok;

   logic [SR_BITS-1:0] sr_q, sr_d, led_data_q, led_data_d;
   logic frm_valid_q, frm_valid_d, frm_err_q, frm_err_d;
   logic [15:0] frm_cnt_q, frm_cnt_d, err_cnt_q, err_cnt_d;
   logic [31:0] acc_q, acc_d, acc_inc, on_cnt_q, on_cnt_d;

   // Input pipeline: one capture stage for every pin, plus a second stage on sclk and lat.
   always_comb begin
      sclk_d     = disp_sclk;
      sin_d      = disp_sin;
      lat_d      = disp_lat;
      blank_d    = disp_blank;
      sclk_dly_d = sclk_q;
      lat_dly_d  = lat_q;
   end

   assign sclk_rise = sclk_q & ~sclk_dly_q;
   assign lat_rise  = lat_q & ~lat_dly_q;

   // Input pipeline registers. The blank stage resets to 1 so the LEDs stay dark.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_q     <= 1'b0;
         sclk_dly_q <= 1'b0;
         sin_q      <= 1'b0;
         lat_q      <= 1'b0;
         lat_dly_q  <= 1'b0;
         blank_q    <= 1'b1;
      end else begin
         sclk_q     <= sclk_d;
         sclk_dly_q <= sclk_dly_d;
         sin_q      <= sin_d;
         lat_q      <= lat_d;
         lat_dly_q  <= lat_dly_d;
         blank_q    <= blank_d;
      end
   end

   // Bit count after any shift in this cycle. A coincident latch judges the frame with this value.
   always_comb begin
      cnt_adv = cnt_q;
      if (sclk_rise && (cnt_q != CNT_OVER)) cnt_adv = cnt_q + 1'b1;
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state. A shift advances the state, and any latch returns it to IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_adv;
      if (sclk_rise) begin
         case (state_q)
            ST_IDLE:  state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CNT_FULL) state_d = ST_OVER;
            default:  state_d = state_q;
         endcase
      end
      if (lat_rise) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   // FSM outputs: frame verdict pulses, registered one cycle after the latch edge
   always_comb begin
      frame_ok    = (cnt_adv == CNT_FULL);
      frm_valid_d = lat_rise & frame_ok;
      frm_err_d   = lat_rise & ~frame_ok;
   end

   // Datapath next values: the shift register, the latch, the frame counters and the on-time accumulator
   always_comb begin
      sr_d       = sclk_rise ? {sr_q[SR_BITS-2:0], sin_q} : sr_q;
      led_data_d = lat_rise ? sr_d : led_data_q;
      frm_cnt_d  = frm_valid_d ? frm_cnt_q + 16'd1 : frm_cnt_q;
      err_cnt_d  = (frm_err_d && (err_cnt_q != 16'hffff)) ? err_cnt_q + 16'd1 : err_cnt_q;
      acc_inc    = (!blank_q && (acc_q != 32'hffff_ffff)) ? acc_q + 32'd1 : acc_q;
      acc_d      = meas_stb ? 32'd0 : acc_inc;
      on_cnt_d   = meas_stb ? acc_inc : on_cnt_q;
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q        <= '0;
         led_data_q  <= '0;
         frm_valid_q <= 1'b0;
         frm_err_q   <= 1'b0;
         frm_cnt_q   <= '0;
         err_cnt_q   <= '0;
         acc_q       <= '0;
         on_cnt_q    <= '0;
      end else begin
         sr_q        <= sr_d;
         led_data_q  <= led_data_d;
         frm_valid_q <= frm_valid_d;
         frm_err_q   <= frm_err_d;
         frm_cnt_q   <= frm_cnt_d;
         err_cnt_q   <= err_cnt_d;
         acc_q       <= acc_d;
         on_cnt_q    <= on_cnt_d;
      end
   end

   assign led_data  = led_data_q;
   assign led_out   = blank_q ? '0 : led_data_q;
   assign frm_valid = frm_valid_q;
   assign frm_err   = frm_err_q;
   assign frm_cnt   = frm_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign on_cnt    = on_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_disp_sr_rx.sv
// Directed testbench for disp_sr_rx with the default four-driver, 64-bit chain.
module tb_disp_sr_rx;

   localparam int SRB = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic disp_sclk = 1'b0;
   logic disp_sin = 1'b0;
   logic disp_lat = 1'b0;
   logic disp_blank = 1'b1;
   logic meas_stb = 1'b0;
   logic [SRB-1:0] led_data, led_out;
   logic frm_valid, frm_err;
   logic [15:0] frm_cnt, err_cnt;
   logic [31:0] on_cnt;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;
   logic [SRB-1:0] sr_m = '0;
   int nv, ne;

   // Clock and DUT
   always #5 clk = ~clk;

   disp_sr_rx #(.N_DRV(4)) dut (
      .clk(clk), .rst(rst),
      .disp_sclk(disp_sclk), .disp_sin(disp_sin), .disp_lat(disp_lat),
      .disp_blank(disp_blank), .meas_stb(meas_stb),
      .led_data(led_data), .led_out(led_out),
      .frm_valid(frm_valid), .frm_err(frm_err),
      .frm_cnt(frm_cnt), .err_cnt(err_cnt), .on_cnt(on_cnt),
      .dbg_state(dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One sclk pulse: high for one clk, then low for one clk
   task automatic send_bit(input logic b);
      @(negedge clk);
      disp_sin  = b;
      disp_sclk = 1'b1;
      @(negedge clk);
      disp_sclk = 1'b0;
      sr_m = {sr_m[SRB-2:0], b};
   endtask

   // Send the n low bits of w, MSB first
   task automatic send_word(input logic [63:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   // Raise lat (optionally with a coincident sclk edge), then count verdict pulses over four cycles
   task automatic do_lat(input logic with_bit, input logic b, output int v, output int e);
      @(negedge clk);
      disp_lat = 1'b1;
      if (with_bit) begin
         disp_sin  = b;
         disp_sclk = 1'b1;
         sr_m = {sr_m[SRB-2:0], b};
      end
      @(negedge clk);
      disp_lat  = 1'b0;
      disp_sclk = 1'b0;
      v = 0;
      e = 0;
      repeat (4) begin
         @(negedge clk);
         v += int'(frm_valid);
         e += int'(frm_err);
      end
   endtask

   // Toggle blank every clk, or hold it, and strobe meas_stb every 2000 clk, for two windows
   task automatic run_windows(input logic toggle);
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         disp_blank = toggle ? logic'(i % 2) : 1'b1;
         meas_stb   = ((i % 2000) == 1999);
      end
      @(negedge clk);
      meas_stb = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_led_data", led_data, 64'h0);
      check("rst_led_out", led_out, 64'h0);
      check("rst_frm_cnt", frm_cnt, 64'h0);
      check("rst_err_cnt", err_cnt, 64'h0);
      check("rst_on_cnt", on_cnt, 64'h0);
      check("rst_pulses", {frm_valid, frm_err}, 64'h0);
      check("rst_state", dbg_state, 64'h0);
      rst = 1'b0;
      disp_blank = 1'b0;
      repeat (2) @(negedge clk);

      // Good 64-bit frame
      send_word(64'h0123_4567_89ab_cdef, 64);
      check("good_state_shift", dbg_state, 64'h1);
      do_lat(1'b0, 1'b0, nv, ne);
      check("good_led_data", led_data, 64'h0123_4567_89ab_cdef);
      check("good_valid_pulses", nv, 64'd1);
      check("good_err_pulses", ne, 64'd0);
      check("good_frm_cnt", frm_cnt, 64'd1);
      check("good_err_cnt", err_cnt, 64'd0);
      check("good_led_out", led_out, 64'h0123_4567_89ab_cdef);
      check("good_state_idle", dbg_state, 64'h0);

      // Short frame of 63 bits
      send_word(64'h5a5a_f00f_1234_8765, 63);
      do_lat(1'b0, 1'b0, nv, ne);
      check("short_err_pulses", ne, 64'd1);
      check("short_valid_pulses", nv, 64'd0);
      check("short_err_cnt", err_cnt, 64'd2 - 64'd1);
      check("short_state_idle", dbg_state, 64'h0);
      check("short_led_data", led_data, 64'hda5a_f00f_1234_8765);

      // Long frame of 70 bits: the last 64 bits survive
      send_word(64'h3f, 6);
      send_word(64'hfedc_ba98_7654_3210, 64);
      check("long_state_over", dbg_state, 64'h2);
      do_lat(1'b0, 1'b0, nv, ne);
      check("long_err_pulses", ne, 64'd1);
      check("long_err_cnt", err_cnt, 64'd2);
      check("long_led_data", led_data, 64'hfedc_ba98_7654_3210);
      check("long_frm_cnt", frm_cnt, 64'd1);

      // 64th sclk edge coincident with the lat edge
      send_word(64'h1111_2222_3333_4444 >> 1, 63);
      do_lat(1'b1, 1'b0, nv, ne);
      check("coin_valid_pulses", nv, 64'd1);
      check("coin_err_pulses", ne, 64'd0);
      check("coin_led_data", led_data, 64'h1111_2222_3333_4444);
      check("coin_frm_cnt", frm_cnt, 64'd2);

      // Latch with no sclk edges: an error frame, and led_data reloads the same sr
      do_lat(1'b0, 1'b0, nv, ne);
      check("empty_err_pulses", ne, 64'd1);
      check("empty_err_cnt", err_cnt, 64'd3);
      check("empty_led_data", led_data, sr_m);

      // Blank at 50% duty: 1000 of every 2000 cycles are on
      run_windows(1'b1);
      check("duty_on_cnt_in_range", (on_cnt >= 32'd999) && (on_cnt <= 32'd1001), 64'd1);

      // Blank held high: no on-time, and outputs dark while data is held
      run_windows(1'b0);
      check("blank_on_cnt", on_cnt, 64'd0);
      check("blank_led_out", led_out, 64'h0);
      check("blank_led_data", led_data, 64'h1111_2222_3333_4444);

      // Reset in the middle of a frame: the partial bits are discarded
      send_word(64'h2aaa_aaaa, 30);
      @(negedge clk);
      rst = 1'b1;
      #2;
      check("midrst_frm_cnt", frm_cnt, 64'd0);
      check("midrst_err_cnt", err_cnt, 64'd0);
      check("midrst_led_data", led_data, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      sr_m = '0;
      send_word(64'hc001_d00d_beef_cafe, 64);
      do_lat(1'b0, 1'b0, nv, ne);
      check("midrst_valid_pulses", nv, 64'd1);
      check("midrst_err_pulses", ne, 64'd0);
      check("midrst_frm_cnt_after", frm_cnt, 64'd1);
      check("midrst_err_cnt_after", err_cnt, 64'd0);
      check("midrst_led_data_after", led_data, 64'hc001_d00d_beef_cafe);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/disp_sr_rx.md
DISP_SR_RX -- requirements
Module: disp_sr_rx

Interface
REQ-001 Parameter N_DRV, default 4: number of daisy-chained TLC59282 drivers on the display serial chain.
REQ-002 Parameter SR_BITS, default 16*N_DRV: total chain shift-register length in bits.
REQ-003 Port clk  input  1: system clock; one clock, all logic on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port disp_sclk  input  1: serial clock of the LED driver chain, in the clk domain.
REQ-006 Port disp_sin  input  1: serial data into the first driver of the chain.
REQ-007 Port disp_lat  input  1: latch; a rising edge transfers the shift register to the output latch.
REQ-008 Port disp_blank  input  1: 1 = all outputs off.
REQ-009 Port meas_stb  input  1: one-cycle strobe that closes a brightness measurement window (e.g. tsc_1ppms).
REQ-010 Port led_data  output  SR_BITS: latched chain contents.
REQ-011 Port led_out  output  SR_BITS: effective LED state, led_data gated by blank.
REQ-012 Port frm_valid  output  1: one-cycle pulse when a correctly sized frame has been latched.
REQ-013 Port frm_err  output  1: one-cycle pulse when a latch occurs with a bit count other than SR_BITS.
REQ-014 Port frm_cnt  output  16: count of good frames, wraps.
REQ-015 Port err_cnt  output  16: count of bad frames, saturates at 16'hffff.
REQ-016 Port on_cnt  output  32: clk cycles with blank low in the last completed measurement window.

Function
REQ-017 disp_sclk, disp_sin, disp_lat and disp_blank shall each be registered once (the _q stage); sclk and lat shall also be registered a second time for edge detection.
REQ-018 An sclk rise shall be detected when sclk_q=1 and the second stage=0; sclk high and low times of at least 1 clk are supported.
REQ-019 On an sclk rise: sr <= {sr[SR_BITS-2:0], sin_q}, so the first bit shifted in ends at sr[SR_BITS-1].
REQ-020 Bit-count state machine: IDLE (cnt=0), SHIFT (1..SR_BITS), OVER (more than SR_BITS bits). An sclk rise advances IDLE->SHIFT and SHIFT->OVER past SR_BITS; the count saturates at SR_BITS+1.
REQ-021 A lat rise shall be detected from lat_q and its second stage; on it, led_data <= sr, whatever the count.
REQ-022 On a lat rise with cnt==SR_BITS: frm_valid=1 for one cycle and frm_cnt increments; otherwise frm_err=1 for one cycle and err_cnt increments (saturating).
REQ-023 Every lat rise shall return the state machine to IDLE with cnt=0.
REQ-024 An sclk rise and a lat rise in the same cycle: the shift and count are applied first, then the latch uses the shifted sr and the incremented count; the state machine then goes to IDLE.
REQ-025 frm_valid and frm_err are registered, asserted in the cycle after the lat rise is detected, and mutually exclusive.
REQ-026 led_out = blank_q ? '0 : led_data, combinational from registers.
REQ-027 The on-cycle accumulator increments each cycle that blank_q=0 and saturates at 32'hffffffff.
REQ-028 On meas_stb: on_cnt <= accumulator value including the current cycle, and the accumulator restarts at 0.
REQ-029 A latch with no preceding sclk edges is an error frame (cnt=0), and led_data reloads the unchanged sr.

Reset
REQ-030 While rst=1, asynchronously:
- sr, led_data, led_out, frm_cnt, err_cnt, on_cnt and the accumulator are 0.
- frm_valid and frm_err are 0 and the state is IDLE.
- all input pipeline stages are 0.
- the blank stage is 1.
REQ-031 A reset asserted mid-frame discards the partial frame; the first lat after release is judged only on bits shifted after release.

Verification
REQ-032 N_DRV=4, 64 sclk pulses carrying 64'h0123_4567_89ab_cdef MSB first, then lat -> led_data=64'h0123456789abcdef, frm_valid one pulse, frm_cnt=1, frm_err=0.
REQ-033 63 bits then lat -> frm_err pulse, err_cnt=1, state IDLE. Next, 70 bits then lat -> frm_err, err_cnt=2, led_data = last 64 bits shifted.
REQ-034 64th sclk rise coincident with lat rise -> frm_valid, and led_data includes the 64th bit.
REQ-035 blank driven with 0xaa-style 50% duty at 2 clk period, meas_stb every 2000 clk -> on_cnt=1000 (plus or minus 1). blank held 1 -> on_cnt=0 and led_out=0 while led_data is nonzero.
REQ-036 rst pulsed after 30 bits, then 64 bits and lat -> all counters restart, frm_valid, frm_cnt=1, err_cnt=0.
